vga_timing_out: RTL and testbench

- Raster timing generator and pixel output stage for the VGA game datapath.
- Produces the x/y scan coordinates that drive the gamebox renderer.
- Registers the renderer's combinational r/g/b with aligned hsync/vsync/de and drives the VGA connector.
- Supplies frame and line strobes for game-state update logic.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_sync_gen.sv | 69 ++++++
 rtl/vga_timing_out.sv | 93 +++++++++
 tb/tb_vga_timing_out.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Raster timing constants shared by the VGA timing generator and output stage.
// The defaults describe 640x480@60; derived totals and sync windows follow from them.
package vga_timing_pkg;

    localparam int CNT_W = 16;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

endpackage

// File: rtl/vga_sync_gen.sv
// Horizontal/vertical raster counters with combinational region decode.
// Every decoded output is forced inactive while rst is high so that a
// mid-frame reset cannot stretch a sync pulse or emit a stray tick.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
)
(
    input  logic clk,
    input  logic rst,
    output cnt_t h_cnt,
    output cnt_t v_cnt,
    output logic active,
    output logic hs_raw,
    output logic vs_raw,
    output logic line_tick,
    output logic frame_tick
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
    localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
    localparam cnt_t HS_START = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    // Pixel counter wraps each line; line counter advances on the last pixel of a line.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
        end else begin
            h_cnt <= h_cnt + cnt_t'(1);
        end
    end

    // Region decode; vsync only depends on v_cnt so it naturally changes at h_cnt = 0.
    always_comb begin
        active     = 1'b0;
        hs_raw     = 1'b0;
        vs_raw     = 1'b0;
        line_tick  = 1'b0;
        frame_tick = 1'b0;
        if (!rst) begin
            active     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
            hs_raw     = (h_cnt >= HS_START) && (h_cnt < HS_END);
            vs_raw     = (v_cnt >= VS_START) && (v_cnt < VS_END);
            line_tick  = (h_cnt == H_LAST);
            frame_tick = (v_cnt == V_VIS) && (h_cnt == '0);
        end
    end

endmodule

// File: rtl/vga_timing_out.sv
// VGA raster timing plus the pixel output register stage.
// x/y are exported combinationally to the renderer; its colour comes back
// combinationally and is registered together with syncs and data enable,
// giving one clock from x/y to the connector pins.
module vga_timing_out
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        active,
    output logic        line_tick,
    output logic        frame_tick,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de
);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic hs_raw;
    logic vs_raw;

    vga_sync_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .hs_raw     (hs_raw),
        .vs_raw     (vs_raw),
        .line_tick  (line_tick),
        .frame_tick (frame_tick)
    );

    // Coordinates read as 0 outside the visible area so the renderer never sees blanking positions.
    always_comb begin
        x = '0;
        y = '0;
        if (active) begin
            x = h_cnt;
            y = v_cnt;
        end
    end

    // Output register stage: colour, enable and syncs all leave on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_de <= 1'b0;
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else begin
            vga_de <= active;
            vga_r  <= active ? r_in : 8'h00;
            vga_g  <= active ? g_in : 8'h00;
            vga_b  <= active ? b_in : 8'h00;
            vga_hs <= hs_raw ? HS_POL : ~HS_POL;
            vga_vs <= vs_raw ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
// Bench for vga_timing_out: a reduced-size raster instance checked every cycle
// against a position-in-frame model, plus a default 640x480 instance whose
// line timing is measured directly.
module tb_vga_timing_out;

    // Reduced raster so several frames fit in a short run.
    localparam int HA = 16, HF = 4, HS = 6, HB = 5;
    localparam int VA = 10, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;   // 31
    localparam int VT = VA + VF + VS + VB;   // 19
    localparam int FR = HT * VT;             // 589

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    // Small-raster instance.
    logic [15:0] x, y;
    logic        active, line_tick, frame_tick;
    logic [7:0]  r_in, g_in, b_in, vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de;

    // Default 640x480 instance.
    logic [15:0] d_x, d_y;
    logic        d_active, d_lt, d_ft;
    logic [7:0]  d_r_in = 8'hAA, d_g_in = 8'h55, d_b_in = 8'h0F;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_de;

    assign r_in = mode ? x[7:0] : 8'hAA;
    assign g_in = mode ? y[7:0] : 8'h55;
    assign b_in = mode ? (x[7:0] ^ y[7:0]) : 8'h0F;

    always #5 clk = ~clk;

    vga_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .active(active),
        .line_tick(line_tick), .frame_tick(frame_tick),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
    );

    vga_timing_out dut_def (
        .clk(clk), .rst(rst), .x(d_x), .y(d_y), .active(d_active),
        .line_tick(d_lt), .frame_tick(d_ft),
        .r_in(d_r_in), .g_in(d_g_in), .b_in(d_b_in),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // k = clocks elapsed since the raster last left reset; position follows by division.
    int   k = 0;
    logic armed = 1'b0;
    logic       e_de, e_hs, e_vs;
    logic [7:0] e_r, e_g, e_b;

    function automatic int hp(input int kk); return kk % HT; endfunction
    function automatic int vp(input int kk); return (kk / HT) % VT; endfunction
    function automatic logic act_m(input int kk);
        return (hp(kk) < HA) && (vp(kk) < VA);
    endfunction
    function automatic logic hs_m(input int kk);
        return (hp(kk) >= HA + HF) && (hp(kk) < HA + HF + HS);
    endfunction
    function automatic logic vs_m(input int kk);
        return (vp(kk) >= VA + VF) && (vp(kk) < VA + VF + VS);
    endfunction

    always @(posedge clk) begin
        armed <= armed || rst;
        if (rst) begin
            k <= 0;
            e_de <= 1'b0; e_r <= 8'h00; e_g <= 8'h00; e_b <= 8'h00;
            e_hs <= 1'b1; e_vs <= 1'b1;
        end else begin
            k    <= k + 1;
            e_de <= act_m(k);
            e_r  <= !act_m(k) ? 8'h00 : (mode ? 8'(hp(k)) : 8'hAA);
            e_g  <= !act_m(k) ? 8'h00 : (mode ? 8'(vp(k)) : 8'h55);
            e_b  <= !act_m(k) ? 8'h00 : (mode ? (8'(hp(k)) ^ 8'(vp(k))) : 8'h0F);
            e_hs <= !hs_m(k);
            e_vs <= !vs_m(k);
        end
    end

    // Per-cycle comparison of every output of the small instance.
    always @(negedge clk) begin
        if (armed) begin
            chk("m_active", 32'(active),     32'(!rst && act_m(k)));
            chk("m_x",      32'(x),          (!rst && act_m(k)) ? hp(k) : 0);
            chk("m_y",      32'(y),          (!rst && act_m(k)) ? vp(k) : 0);
            chk("m_line",   32'(line_tick),  32'(!rst && hp(k) == HT - 1));
            chk("m_frame",  32'(frame_tick), 32'(!rst && vp(k) == VA && hp(k) == 0));
            chk("m_de",     32'(vga_de), 32'(e_de));
            chk("m_r",      32'(vga_r),  32'(e_r));
            chk("m_g",      32'(vga_g),  32'(e_g));
            chk("m_b",      32'(vga_b),  32'(e_b));
            chk("m_hs",     32'(vga_hs), 32'(e_hs));
            chk("m_vs",     32'(vga_vs), 32'(e_vs));
        end
    end

    // ---------------- directed checks ----------------
    task automatic measure_default();
        int rise_n = -1, fall1 = -1, fall2 = -1, low_len = 0, de_cnt = 0;
        logic pde = 1'b0, phs = 1'b1;
        for (int n = 0; n < 1700; n++) begin
            @(negedge clk);
            if (d_de && !pde && rise_n < 0) rise_n = n;
            if (!d_hs && phs) begin
                if (fall1 < 0) fall1 = n;
                else if (fall2 < 0) fall2 = n;
            end
            if (!d_hs && fall1 >= 0 && fall2 < 0) low_len++;
            if (n < 800 && d_de) de_cnt++;
            if (n < 800) chk("def_vs_idle", 32'(d_vs), 1);
            pde = d_de;
            phs = d_hs;
        end
        chk("def_de_to_hs", fall1 - rise_n, 656);
        chk("def_hs_low", low_len, 96);
        chk("def_line_period", fall2 - fall1, 800);
        chk("def_de_high", de_cnt, 640);
    endtask

    task automatic literal_small();
        int lt_last = -1, ft_last = -1, vs_fall = -1;
        logic pvs = 1'b1;
        for (int n = 0; n < 1700; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk("rel_active", 32'(active), 1);
                chk("rel_x", 32'(x), 0);
                chk("rel_y", 32'(y), 0);
            end
            if (n == 1)  chk("rgb_aa_in_de", 32'(vga_r), 32'h00AA);
            if (n == 16) chk("rgb_aa_last", 32'(vga_r), 32'h00AA);
            if (n == 17) chk("rgb_zero_blank", 32'(vga_r), 0);
            if (n == 294) begin
                chk("last_pix_x", 32'(x), 15);
                chk("last_pix_y", 32'(y), 9);
                chk("last_pix_act", 32'(active), 1);
            end
            if (n == 295) begin
                chk("after_last_act", 32'(active), 0);
                chk("after_last_x", 32'(x), 0);
            end
            if (n == 588) chk("wrap_line_tick", 32'(line_tick), 1);
            if (n == 589) begin
                chk("wrap_x", 32'(x), 0);
                chk("wrap_y", 32'(y), 0);
                chk("wrap_act", 32'(active), 1);
            end
            if (line_tick) begin
                if (lt_last >= 0) chk("line_period", n - lt_last, 31);
                lt_last = n;
            end
            if (frame_tick) begin
                if (ft_last >= 0) chk("frame_period", n - ft_last, 589);
                ft_last = n;
            end
            if (!vga_vs && pvs) begin
                vs_fall = n;
                chk("vs_after_ft", n - ft_last, 63);
            end
            if (vga_vs && !pvs) chk("vs_low_len", n - vs_fall, 93);
            pvs = vga_vs;
        end
    endtask

    task automatic wait_pos(input int pos, input string nm);
        logic found = 1'b0;
        for (int i = 0; i < 1300 && !found; i++) begin
            @(negedge clk);
            if (k % FR == pos) found = 1'b1;
        end
        chk(nm, 32'(found), 1);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hs", 32'(vga_hs), 1);
        chk("rst_vs", 32'(vga_vs), 1);
        chk("rst_de", 32'(vga_de), 0);
        chk("rst_rgb", {8'h00, vga_r, vga_g, vga_b}, 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_xy", {x, y}, 0);
        chk("rst_ticks", {30'h0, line_tick, frame_tick}, 0);
        chk("rst_def_outs", {d_x, d_y}, 0);
        chk("rst_def_ctl", {26'h0, d_active, d_lt, d_ft, d_de, d_hs, d_vs}, 32'h3);
        chk("rst_def_rgb", {8'h00, d_r, d_g, d_b}, 0);
        @(posedge clk); #2 rst = 1'b0;

        fork
            measure_default();
            literal_small();
        join

        // Colour follows the coordinates with one clock of latency.
        @(posedge clk); #2 mode = 1'b1;
        repeat (2) @(posedge clk);
        wait_pos(6, "tmo_pos6");
        chk("lat_r", 32'(vga_r), 5);
        chk("lat_g", 32'(vga_g), 0);
        chk("lat_b", 32'(vga_b), 5);
        wait_pos(3 * HT + 8, "tmo_pos101");
        chk("lat_r2", 32'(vga_r), 7);
        chk("lat_g2", 32'(vga_g), 3);
        chk("lat_b2", 32'(vga_b), 4);

        // Reset in the middle of both sync pulses (h=22, v=12).
        begin
            logic found = 1'b0;
            for (int i = 0; i < 1300 && !found; i++) begin
                @(posedge clk); #2;
                if (k % FR == 12 * HT + 22) found = 1'b1;
            end
            chk("tmo_midrst", 32'(found), 1);
        end
        chk("pre_rst_hs", 32'(vga_hs), 0);
        chk("pre_rst_vs", 32'(vga_vs), 0);
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        chk("midrst_hs", 32'(vga_hs), 1);
        chk("midrst_vs", 32'(vga_vs), 1);
        begin
            logic found = 1'b0;
            for (int n = 0; n < 1000 && !found; n++) begin
                @(negedge clk);
                if (n == 0) begin
                    chk("resume_xy", {x, y}, 0);
                    chk("resume_act", 32'(active), 1);
                end
                if (frame_tick) begin
                    found = 1'b1;
                    chk("midrst_ft_delay", n, 310);
                end
            end
            chk("tmo_midrst_ft", 32'(found), 1);
        end

        repeat (50) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
